tdm_demux: RTL and testbench
============================

# tdm_demux

Receive side of the two-slot time-multiplexed nibble bus driven by the display mux. Slot 0 is carried while `sel` is low and slot 1 while `sel` is high. The block watches `sel`, waits a settle time after each phase change, and captures the bus into the correct slot. After each complete slot0→slot1 frame it publishes both nibbles through a valid/ready handshake. It sits at the far end of the shared bus, for loop-back checking and for board-to-board links, and flags overruns, glitches and a stalled phase signal.

## Interface
- `WIDTH`, 4: bus and slot width in bits.
- `SETTLE`, 2: cycles from a detected `sel` edge to the capture cycle; legal range 1..15.
- `TIMEOUT`, 255: cycles without any `sel` edge before `stall_err` is set; legal range 4..65535.

- `clk` in 1: single system clock; everything is sampled on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sel` in 1: phase of the multiplexed bus; 0 = slot 0, 1 = slot 1.
- `bus` in WIDTH: multiplexed data.
- `out_ready` in 1: consumer accepts the published frame.
- `clr_err` in 1: one-cycle pulse that clears the sticky flags.
- `slot0` out WIDTH: captured slot-0 value of the last published frame.
- `slot1` out WIDTH: captured slot-1 value of the last published frame.
- `out_valid` out 1: a frame is available; held until accepted.
- `overrun` out 1: sticky; an unaccepted frame was overwritten.
- `glitch_err` out 1: sticky; `sel` changed during a settle window.
- `stall_err` out 1: sticky; no `sel` edge for TIMEOUT cycles.

## Operation
- **Edge detection:** the registered `sel_q` holds the previous `sel`. An edge is `sel != sel_q`. A falling edge is `sel_q=1`, `sel=0`.
- **FSM states:**
  - WAIT0: a falling edge moves to SETTLE0; rising edges are ignored.
  - SETTLE0: count to SETTLE, then capture `bus`→`cap0` and go to WAIT1.
  - WAIT1: a rising edge moves to SETTLE1; a falling edge moves to SETTLE0 and restarts the frame.
  - SETTLE1: count to SETTLE, then capture `bus`→`cap1`, publish, and go to WAIT0.
- **Glitch:** any `sel` edge during SETTLE0 or SETTLE1 sets `glitch_err`, discards the partial frame and returns to WAIT0. If that edge is a falling edge, go straight to SETTLE0 instead.
- **Publish:** `slot0`←`cap0`, `slot1`←`cap1`, `out_valid`←1.
  - If `out_valid=1` and `out_ready=0` on the publish cycle, set `overrun`; the new data replaces the old.
- **Handshake:**
  - A transfer occurs on a cycle with `out_valid && out_ready`. After a transfer with no publish, `out_valid` clears on the next cycle.
  - A transfer and a publish in the same cycle leave `out_valid=1` with the new data, and do not set `overrun`.
- **Timeout:**
  - A 16-bit counter clears on every `sel` edge and saturates at TIMEOUT.
  - On reaching TIMEOUT it sets `stall_err` and forces the FSM to WAIT0.
  - Published data is kept.
- **`clr_err`:** clears all three sticky flags.
  - If a flag's set condition is true in the same cycle, set wins.
- **Reset values:** `slot0`=0, `slot1`=0, `out_valid`=0, all flags=0, FSM=WAIT0, `sel_q`=0, counters=0.
  - If `sel`=1 when reset is released, the resulting rising edge is ignored.
- **Reset mid-frame:** the partial frame is lost and nothing is published.

## Timing
- An edge is detected in cycle N; the capture happens in cycle N+SETTLE.
- `out_valid` rises in cycle N1+SETTLE+1, where N1 is the slot-1 edge cycle.
- Minimum slot length is SETTLE+1 cycles. Shorter slots produce `glitch_err`.
- Throughput is one frame per `sel` period; there is no internal buffering beyond one frame.

## Configuration
- `TDM_DEMUX_SYNC_EN`
  - Defined: `sel` and `bus` pass through a 2-flop synchronizer before edge detection. This adds 2 cycles to every latency above; the macro is for off-board or asynchronous sources.
  - Undefined: `sel` and `bus` are used directly and must be synchronous to `clk`.

## Structure
- A shared package `tdm_pkg` holds:
  - the state enum `tdm_state_t` (WAIT0, SETTLE0, WAIT1, SETTLE1);
  - the default constants `TDM_WIDTH`=4 and `TDM_SETTLE`=2.
- One sub-module, `tdm_sync`: a 2-flop synchronizer, parameterized by width, instantiated only under `TDM_DEMUX_SYNC_EN`.

## Test plan
- **Basic frame:** SETTLE=2; `sel` period 20 cycles (10 low/10 high); `bus`=4'b0001 in slot 0 and 4'b1000 in slot 1; `out_ready`=1 → each frame publishes `slot0`=0001, `slot1`=1000, with `out_valid` rising 3 cycles after each rising `sel` edge.
- **Backpressure:** `out_ready`=0 for two frames (0x3/0xC, then 0x5/0xA) → `slot0`=0x5, `slot1`=0xA, `overrun`=1 and `out_valid` held; raising `out_ready` for one cycle → `out_valid`=0 on the next cycle.
- **Glitch:** `sel` pulses high for 1 cycle inside slot 0 → `glitch_err`=1, no publish for that frame, and the next clean frame publishes correctly.
- **Stall:** TIMEOUT=16; `sel` held at 0 for 20 cycles → `stall_err`=1 exactly 16 cycles after the last edge; `clr_err` pulse → `stall_err`=0.
- **Reset mid-frame:** assert `rst` during SETTLE1 → all outputs 0 on the next cycle and no stale frame afterwards; the first valid frame needs a falling edge.
- **Simultaneous accept and publish:** `out_ready`=1 on the publish cycle while `out_valid`=1 → new data shown, `out_valid` stays 1, `overrun` stays 0.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and default constants for the TDM nibble-bus receiver.
package tdm_pkg;

  localparam int TDM_WIDTH  = 4;
  localparam int TDM_SETTLE = 2;

  typedef enum logic [1:0] {
    WAIT0   = 2'd0,
    SETTLE0 = 2'd1,
    WAIT1   = 2'd2,
    SETTLE1 = 2'd3
  } tdm_state_t;

endpackage

// File: rtl/tdm_sync.sv
// Two-flop synchronizer for a bundle of asynchronous inputs.
module tdm_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability chain
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/tdm_demux.sv
// Receive side of the two-slot TDM nibble bus: settles, captures and publishes frames.
// Optional input synchronizer enabled by defining TDM_DEMUX_SYNC_EN.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int WIDTH   = TDM_WIDTH,
  parameter int SETTLE  = TDM_SETTLE,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [WIDTH-1:0] bus,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] slot0,
  output logic [WIDTH-1:0] slot1,
  output logic             out_valid,
  output logic             overrun,
  output logic             glitch_err,
  output logic             stall_err
);

  localparam logic [3:0]  SETTLE_C  = 4'(SETTLE);
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
  localparam logic [15:0] REACH_C   = 16'(TIMEOUT - 1);

  logic             sel_s;
  logic [WIDTH-1:0] bus_s;

`ifdef TDM_DEMUX_SYNC_EN
  logic [WIDTH:0] sync_q_s;

  tdm_sync #(.WIDTH(WIDTH + 1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({sel, bus}),
    .q   (sync_q_s)
  );

  assign sel_s = sync_q_s[WIDTH];
  assign bus_s = sync_q_s[WIDTH-1:0];
`else
  assign sel_s = sel;
  assign bus_s = bus;
`endif

  logic             sel_q_r;
  tdm_state_t       state_r;
  tdm_state_t       case_state_s;
  tdm_state_t       state_next_s;
  logic [3:0]       set_cnt_r;
  logic [3:0]       case_cnt_s;
  logic [3:0]       set_cnt_next_s;
  logic [15:0]      tmo_cnt_r;
  logic [15:0]      tmo_cur_s;
  logic [15:0]      tmo_next_s;
  logic             edge_s;
  logic             rise_s;
  logic             fall_s;
  logic             reach_s;
  logic             cap0_raw_s;
  logic             publish_raw_s;
  logic             cap0_en_s;
  logic             publish_s;
  logic             glitch_s;
  logic             transfer_s;
  logic             overrun_set_s;
  logic [WIDTH-1:0] cap0_r;
  logic [WIDTH-1:0] slot0_r;
  logic [WIDTH-1:0] slot1_r;
  logic             out_valid_r;
  logic             overrun_r;
  logic             glitch_err_r;
  logic             stall_err_r;

  assign edge_s = sel_s ^ sel_q_r;
  assign rise_s = sel_s & ~sel_q_r;
  assign fall_s = ~sel_s & sel_q_r;

  // The edge cycle itself counts as zero, so the counter equals TIMEOUT when stall_err appears
  assign tmo_cur_s  = edge_s ? 16'd0 : tmo_cnt_r;
  assign tmo_next_s = (tmo_cur_s == TIMEOUT_C) ? TIMEOUT_C : tmo_cur_s + 16'd1;
  assign reach_s    = (tmo_cur_s == REACH_C);

  // Frame sequencing: phase waits, settle windows and glitch recovery
  always_comb begin
    case_state_s  = state_r;
    case_cnt_s    = set_cnt_r;
    cap0_raw_s    = 1'b0;
    publish_raw_s = 1'b0;
    glitch_s      = 1'b0;
    case (state_r)
      WAIT0: begin
        if (fall_s) begin
          case_state_s = SETTLE0;
          case_cnt_s   = 4'd1;
        end else begin
          case_cnt_s   = 4'd0;
        end
      end
      SETTLE0, SETTLE1: begin
        if (edge_s) begin
          glitch_s = 1'b1;
          if (fall_s) begin
            case_state_s = SETTLE0;
            case_cnt_s   = 4'd1;
          end else begin
            case_state_s = WAIT0;
            case_cnt_s   = 4'd0;
          end
        end else if (set_cnt_r == SETTLE_C) begin
          case_cnt_s = 4'd0;
          if (state_r == SETTLE0) begin
            cap0_raw_s   = 1'b1;
            case_state_s = WAIT1;
          end else begin
            publish_raw_s = 1'b1;
            case_state_s  = WAIT0;
          end
        end else begin
          case_cnt_s = set_cnt_r + 4'd1;
        end
      end
      WAIT1: begin
        if (rise_s) begin
          case_state_s = SETTLE1;
          case_cnt_s   = 4'd1;
        end else if (fall_s) begin
          case_state_s = SETTLE0;
          case_cnt_s   = 4'd1;
        end else begin
          case_cnt_s   = 4'd0;
        end
      end
      default: begin
        case_state_s = WAIT0;
        case_cnt_s   = 4'd0;
      end
    endcase
  end

  // A stalled phase signal overrides whatever the frame sequencer wanted
  assign state_next_s   = reach_s ? WAIT0 : case_state_s;
  assign set_cnt_next_s = reach_s ? 4'd0 : case_cnt_s;
  assign cap0_en_s      = cap0_raw_s & ~reach_s;
  assign publish_s      = publish_raw_s & ~reach_s;

  assign transfer_s    = out_valid_r & out_ready;
  assign overrun_set_s = publish_s & out_valid_r & ~out_ready;

  // Phase history, settle/timeout counters and FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q_r   <= 1'b0;
      state_r   <= WAIT0;
      set_cnt_r <= 4'd0;
      tmo_cnt_r <= 16'd0;
    end else begin
      sel_q_r   <= sel_s;
      state_r   <= state_next_s;
      set_cnt_r <= set_cnt_next_s;
      tmo_cnt_r <= tmo_next_s;
    end
  end

  // Slot capture, frame publish and valid/ready handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      cap0_r      <= '0;
      slot0_r     <= '0;
      slot1_r     <= '0;
      out_valid_r <= 1'b0;
    end else begin
      if (cap0_en_s) begin
        cap0_r <= bus_s;
      end
      if (publish_s) begin
        slot0_r     <= cap0_r;
        slot1_r     <= bus_s;
        out_valid_r <= 1'b1;
      end else if (transfer_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // Sticky error flags; a same-cycle set beats clr_err
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_r    <= 1'b0;
      glitch_err_r <= 1'b0;
      stall_err_r  <= 1'b0;
    end else begin
      overrun_r    <= overrun_set_s | (overrun_r & ~clr_err);
      glitch_err_r <= glitch_s | (glitch_err_r & ~clr_err);
      stall_err_r  <= reach_s | (stall_err_r & ~clr_err);
    end
  end

  assign slot0      = slot0_r;
  assign slot1      = slot1_r;
  assign out_valid  = out_valid_r;
  assign overrun    = overrun_r;
  assign glitch_err = glitch_err_r;
  assign stall_err  = stall_err_r;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: frame vector table, scoreboard of published
// frames, and hand-written backpressure, glitch, stall and reset sequences.
module tb_tdm_demux;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic [3:0] bus;
  logic       out_ready;
  logic       clr_err;
  logic [3:0] slot0;
  logic [3:0] slot1;
  logic       out_valid;
  logic       overrun;
  logic       glitch_err;
  logic       stall_err;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    logic [3:0] s0;
    logic [3:0] s1;
  } vec_t;

  vec_t vecs[4];

  tdm_demux #(.WIDTH(4), .SETTLE(2), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .bus        (bus),
    .out_ready  (out_ready),
    .clr_err    (clr_err),
    .slot0      (slot0),
    .slot1      (slot1),
    .out_valid  (out_valid),
    .overrun    (overrun),
    .glitch_err (glitch_err),
    .stall_err  (stall_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // One clock: mid-cycle scoreboard check of any transfer, then return 1 time unit after posedge.
  task automatic tick();
    logic [7:0] exp;
    @(negedge clk);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_frame: got %h/%h, required no transfer", slot0, slot1);
      end else begin
        exp = sb_q.pop_front();
        check("sb_slot0", {28'd0, slot0}, {28'd0, exp[7:4]});
        check("sb_slot1", {28'd0, slot1}, {28'd0, exp[3:0]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [3:0] s0, input logic [3:0] s1);
    sel = 1'b0;
    bus = s0;
    repeat (10) tick();
    sel = 1'b1;
    bus = s1;
    sb_q.push_back({s0, s1});
    repeat (10) tick();
  endtask

  initial begin
    vecs[0] = '{s0: 4'b0001, s1: 4'b1000};
    vecs[1] = '{s0: 4'hF,    s1: 4'h0};
    vecs[2] = '{s0: 4'hA,    s1: 4'h5};
    vecs[3] = '{s0: 4'h6,    s1: 4'h9};

    rst = 1'b1; sel = 1'b0; bus = 4'h0; out_ready = 1'b0; clr_err = 1'b0;
    repeat (3) tick();
    check("rst_outputs", {26'd0, slot0, slot1, out_valid, overrun, glitch_err, stall_err}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;

    // Rising edge straight after reset is ignored
    sel = 1'b1; bus = 4'h0;
    repeat (10) tick();
    check("no_frame_after_reset", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      sel = 1'b0; bus = vecs[i].s0;
      repeat (10) tick();
      sel = 1'b1; bus = vecs[i].s1;
      sb_q.push_back({vecs[i].s0, vecs[i].s1});
      tick(); tick();
      check("valid_edge_plus2", {31'd0, out_valid}, 32'd0);
      tick();
      check("valid_edge_plus3", {31'd0, out_valid}, 32'd1);
      check("vec_slot0", {28'd0, slot0}, {28'd0, vecs[i].s0});
      check("vec_slot1", {28'd0, slot1}, {28'd0, vecs[i].s1});
      tick();
      check("valid_after_accept", {31'd0, out_valid}, 32'd0);
      repeat (6) tick();
    end

    // Backpressure: second frame overwrites the first
    out_ready = 1'b0;
    frame(4'h3, 4'hC);
    check("bp_overrun_first", {31'd0, overrun}, 32'd0);
    check("bp_valid_first", {31'd0, out_valid}, 32'd1);
    sb_q.delete(0);
    frame(4'h5, 4'hA);
    check("bp_slot0", {28'd0, slot0}, 32'h5);
    check("bp_slot1", {28'd0, slot1}, 32'hA);
    check("bp_overrun", {31'd0, overrun}, 32'd1);
    check("bp_valid_held", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_valid_cleared", {31'd0, out_valid}, 32'd0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("bp_overrun_clr", {31'd0, overrun}, 32'd0);

    // Glitch: one-cycle high pulse inside slot 0
    out_ready = 1'b1;
    check("gl_flag_before", {31'd0, glitch_err}, 32'd0);
    sel = 1'b0; bus = 4'h7;
    repeat (4) tick();
    sel = 1'b1;
    tick();
    sel = 1'b0; bus = 4'h2;
    repeat (2) tick();
    check("gl_flag_set", {31'd0, glitch_err}, 32'd1);
    check("gl_no_publish", {31'd0, out_valid}, 32'd0);
    repeat (7) tick();
    sel = 1'b1; bus = 4'hD;
    sb_q.push_back({4'h2, 4'hD});
    repeat (3) tick();
    check("gl_next_valid", {31'd0, out_valid}, 32'd1);
    check("gl_next_slot0", {28'd0, slot0}, 32'h2);
    check("gl_next_slot1", {28'd0, slot1}, 32'hD);
    repeat (7) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("gl_flag_clr", {31'd0, glitch_err}, 32'd0);

    // Stall: sel held low past TIMEOUT
    sel = 1'b0; bus = 4'h0;
    repeat (15) tick();
    check("stall_at_15", {31'd0, stall_err}, 32'd0);
    tick();
    check("stall_at_16", {31'd0, stall_err}, 32'd1);
    repeat (4) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("stall_clr", {31'd0, stall_err}, 32'd0);
    sel = 1'b1; bus = 4'hF;
    repeat (10) tick();
    check("stall_forced_wait0", {31'd0, out_valid}, 32'd0);
    frame(4'h6, 4'h9);

    // Reset in the middle of SETTLE1
    out_ready = 1'b0;
    frame(4'h4, 4'hB);
    check("rm_valid_before", {31'd0, out_valid}, 32'd1);
    sel = 1'b0; bus = 4'hE;
    repeat (10) tick();
    sel = 1'b1; bus = 4'h1;
    tick();
    rst = 1'b1;
    tick();
    sb_q.delete();
    check("rm_outputs_zero", {26'd0, slot0, slot1, out_valid, overrun, glitch_err, stall_err}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    check("rm_no_stale", {31'd0, out_valid}, 32'd0);
    frame(4'h8, 4'h3);

    // Accept and publish in the same cycle
    out_ready = 1'b0;
    frame(4'h9, 4'h6);
    sel = 1'b0; bus = 4'hC;
    repeat (10) tick();
    sel = 1'b1; bus = 4'h3;
    sb_q.push_back({4'hC, 4'h3});
    tick(); tick();
    out_ready = 1'b1;
    tick();
    check("sim_valid", {31'd0, out_valid}, 32'd1);
    check("sim_slot0", {28'd0, slot0}, 32'hC);
    check("sim_slot1", {28'd0, slot1}, 32'h3);
    check("sim_no_overrun", {31'd0, overrun}, 32'd0);
    tick();
    check("sim_drained", {31'd0, out_valid}, 32'd0);
    repeat (8) tick();

    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
